// File: rtl/div_seq_if.sv
// Handshake and result bundle for the sequential divider div_seq.
// The master side drives start and the operands; the slave side returns the results and ALU flags.
interface div_seq_if #(
    parameter int M = 4
);
    logic         start;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic [M-1:0] Q;
    logic [M-1:0] R;
    logic         busy;
    logic         done;
    logic         C;
    logic         N;
    logic         V;
    logic         Z;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, C, N, V, Z
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, C, N, V, Z
    );
endinterface

// File: rtl/div_seq.sv
// Restoring divider that produces one quotient bit per clock, with ALU flags C/N/V/Z.
// Define DIV_SIGNED_EN for two's-complement operands; leave it undefined for unsigned operands.
module div_seq #(
    parameter int M = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    div_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(M) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [M-1:0]   r_rem, w_rem_nxt;
    logic [M-1:0]   r_quo, w_quo_nxt;
    logic [M-1:0]   r_dvs, w_dvs_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [M-1:0]   r_q, w_q_nxt;
    logic [M-1:0]   r_r, w_r_nxt;
    logic           r_c, w_c_nxt;
    logic           r_n, w_n_nxt;
    logic           r_v, w_v_nxt;
    logic           r_z, w_z_nxt;
    logic           w_load;

    // Trial subtraction is one bit wider than the operands; its top bit is the borrow.
    logic [M:0]     w_shift;
    logic [M:0]     w_trial;

`ifdef DIV_SIGNED_EN
    localparam logic [M-1:0] MIN_VAL = {1'b1, {(M-1){1'b0}}};
    logic         r_neg_a, w_neg_a_nxt;
    logic         r_neg_q, w_neg_q_nxt;
    logic [M-1:0] w_abs_a, w_abs_b;

    assign w_abs_a = bus.A[M-1] ? (-bus.A) : bus.A;
    assign w_abs_b = bus.B[M-1] ? (-bus.B) : bus.B;
`endif

    assign w_shift = {r_rem, r_quo[M-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dvs_nxt   = r_dvs;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_v_nxt     = r_v;
        w_c_nxt     = r_c;
        w_n_nxt     = r_n;
        w_z_nxt     = r_z;
        w_load      = 1'b0;
`ifdef DIV_SIGNED_EN
        w_neg_a_nxt = r_neg_a;
        w_neg_q_nxt = r_neg_q;
`endif
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        w_q_nxt     = '1;
                        w_r_nxt     = bus.A;
                        w_v_nxt     = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = DONE;
`ifdef DIV_SIGNED_EN
                    end else if (bus.A == MIN_VAL && bus.B == '1) begin
                        w_q_nxt     = bus.A;
                        w_r_nxt     = '0;
                        w_v_nxt     = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_rem_nxt   = '0;
                        w_quo_nxt   = w_abs_a;
                        w_dvs_nxt   = w_abs_b;
                        w_neg_a_nxt = bus.A[M-1];
                        w_neg_q_nxt = bus.A[M-1] ^ bus.B[M-1];
                        w_cnt_nxt   = '0;
                        w_state_nxt = DIV;
                    end
`else
                    end else begin
                        w_rem_nxt   = '0;
                        w_quo_nxt   = bus.A;
                        w_dvs_nxt   = bus.B;
                        w_cnt_nxt   = '0;
                        w_state_nxt = DIV;
                    end
`endif
                end
            end
            DIV: begin
                if (!w_trial[M]) begin
                    w_rem_nxt = w_trial[M-1:0];
                    w_quo_nxt = {r_quo[M-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_shift[M-1:0];
                    w_quo_nxt = {r_quo[M-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
                w_q_nxt = r_neg_q ? (-r_quo) : r_quo;
                w_r_nxt = r_neg_a ? (-r_rem) : r_rem;
`else
                w_q_nxt = r_quo;
                w_r_nxt = r_rem;
`endif
                w_v_nxt     = 1'b0;
                w_load      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_c_nxt = (w_r_nxt != '0) && !w_v_nxt;
            w_n_nxt = w_q_nxt[M-1];
            w_z_nxt = (w_q_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_a <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_dvs   <= w_dvs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_c     <= w_c_nxt;
            r_n     <= w_n_nxt;
            r_v     <= w_v_nxt;
            r_z     <= w_z_nxt;
`ifdef DIV_SIGNED_EN
            r_neg_a <= w_neg_a_nxt;
            r_neg_q <= w_neg_q_nxt;
`endif
        end
    end

    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.C    = r_c;
    assign bus.N    = r_n;
    assign bus.V    = r_v;
    assign bus.Z    = r_z;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (M = 4) with hand-computed quotients, remainders, flags and latencies.
// Expected values follow DIV_SIGNED_EN so the bench matches either build of the divider.
module tb_div_seq;
    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    div_seq_if #(.M(M)) bus ();

    div_seq #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cmpCount = 0;
    int errCount = 0;
    logic [M-1:0] lastQ = '0;
    logic [M-1:0] lastR = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        cmpCount++;
        if (got !== want) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Starts one division and follows it to done; called #1 after a rising edge.
    // injectAt > 0 pulses start with other operands after that many edges, which must be ignored.
    task automatic applyStimulus(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                                 input int expLat, input logic [M-1:0] expQ, input logic [M-1:0] expR,
                                 input logic [3:0] expFlags, input int injectAt);
        int   edges;
        logic busyOk;
        logic holdOk;
        busyOk    = 1'b1;
        holdOk    = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges     = 1;
        while (!bus.done && edges < 20) begin
            busyOk = busyOk & bus.busy;
            holdOk = holdOk & (bus.Q == lastQ) & (bus.R == lastR);
            if (edges == injectAt) begin
                bus.start = 1'b1;
                bus.A     = 4'b0110;
                bus.B     = 4'b0010;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            edges++;
        end
        checkOutput({tag, ".latency"}, edges, expLat);
        checkOutput({tag, ".done"}, {31'd0, bus.done}, 32'd1);
        checkOutput({tag, ".busy"}, {31'd0, busyOk}, 32'd1);
        checkOutput({tag, ".hold"}, {31'd0, holdOk}, 32'd1);
        checkOutput({tag, ".Q"}, {28'd0, bus.Q}, {28'd0, expQ});
        checkOutput({tag, ".R"}, {28'd0, bus.R}, {28'd0, expR});
        checkOutput({tag, ".CNVZ"}, {28'd0, bus.C, bus.N, bus.V, bus.Z}, {28'd0, expFlags});
        lastQ = expQ;
        lastR = expR;
        @(posedge clk);
        #1;
        checkOutput({tag, ".pulse"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, ".idle"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, ".Qkeep"}, {28'd0, bus.Q}, {28'd0, expQ});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneSeen;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        checkOutput("reset.outputs", {20'd0, bus.Q, bus.R, bus.busy, bus.done, bus.C, bus.N, bus.V, bus.Z}, 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("7div2", 4'b0111, 4'b0010, 6, 4'b0011, 4'b0001, 4'b1000, 0);
`ifdef DIV_SIGNED_EN
        applyStimulus("m7div2", 4'b1001, 4'b0010, 6, 4'b1101, 4'b1111, 4'b1100, 0);
        applyStimulus("6divm3", 4'b0110, 4'b1101, 6, 4'b1110, 4'b0000, 4'b0100, 0);
        applyStimulus("ovf", 4'b1000, 4'b1111, 1, 4'b1000, 4'b0000, 4'b0110, 0);
        applyStimulus("m7divm2", 4'b1001, 4'b1110, 6, 4'b0011, 4'b1111, 4'b1000, 0);
`else
        applyStimulus("9div2", 4'b1001, 4'b0010, 6, 4'b0100, 4'b0001, 4'b1000, 0);
        applyStimulus("6div13", 4'b0110, 4'b1101, 6, 4'b0000, 4'b0110, 4'b1001, 0);
        applyStimulus("8div15", 4'b1000, 4'b1111, 6, 4'b0000, 4'b1000, 4'b1001, 0);
        applyStimulus("9div14", 4'b1001, 4'b1110, 6, 4'b0000, 4'b1001, 4'b1001, 0);
`endif
        applyStimulus("div0", 4'b0101, 4'b0000, 1, 4'b1111, 4'b0101, 4'b0110, 0);
        applyStimulus("8div1", 4'b1000, 4'b0001, 6, 4'b1000, 4'b0000, 4'b0100, 0);
        applyStimulus("1div3inj", 4'b0001, 4'b0011, 6, 4'b0000, 4'b0001, 4'b1001, 2);

        // Abort an operation in its second DIV cycle with an asynchronous reset.
        bus.A     = 4'b0111;
        bus.B     = 4'b0010;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.outputs", {20'd0, bus.Q, bus.R, bus.busy, bus.done, bus.C, bus.N, bus.V, bus.Z}, 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        checkOutput("abort.nodone", doneSeen, 0);
        checkOutput("abort.idle", {31'd0, bus.busy}, 32'd0);
        lastQ = '0;
        lastR = '0;

        applyStimulus("6div3", 4'b0110, 4'b0011, 6, 4'b0010, 4'b0000, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
